multi_timer: RTL

MULTI_TIMER -- requirements
Module: multi_timer

---
 rtl/multi_timer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/multi_timer.sv
// multi_timer: free-running cycle counter with NUM_CH compare channels,
// per-channel pending flags, an interrupt mask and a memory-mapped window.
//
// Ports:
//   clk            - clock, all state updates on the rising edge
//   reset          - asynchronous active-high reset
//   address        - data-memory address from the ALU
//   wdata          - store data
//   MemRead        - load strobe
//   MemWrite       - store strobe
//   rdata          - load data (combinational, zero when not selected)
//   cycle          - free-running cycle count
//   pending        - per-channel pending flags
//   TimerAddress   - address hits the register window
//   TimerInterrupt - OR of pending AND MASK
//
// Register map (byte offsets from BASE_ADDR):
//   0x00 CYCLE (RO), 0x04 ACK (WO, write-1-to-clear), 0x08 STATUS (RO),
//   0x0C MASK (RW), 0x10+4*i COMPARE[i] (RW)
//
// Build option MULTI_TIMER_PERIODIC_EN adds PERIOD[i] at
// 0x10+4*NUM_CH+4*i; a match with a nonzero period advances COMPARE[i]
// by PERIOD[i]. A software COMPARE write in the same cycle wins.

module multi_timer #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned WIDTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF001C
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       address,
    input  logic [31:0]       wdata,
    input  logic              MemRead,
    input  logic              MemWrite,
    output logic [31:0]       rdata,
    output logic [WIDTH-1:0]  cycle,
    output logic [NUM_CH-1:0] pending,
    output logic              TimerAddress,
    output logic              TimerInterrupt
);

    localparam int unsigned CMP_OFF = 16;
`ifdef MULTI_TIMER_PERIODIC_EN
    localparam int unsigned PER_OFF   = CMP_OFF + 4 * NUM_CH;
    localparam int unsigned WIN_BYTES = PER_OFF + 4 * NUM_CH;
`else
    localparam int unsigned WIN_BYTES = CMP_OFF + 4 * NUM_CH;
`endif

    // ------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------
    logic [31:0] off;

    // Unsigned offset: addresses below the base wrap to huge values
    // and fall outside the window automatically.
    assign off = address - BASE_ADDR;

    assign TimerAddress = (address[1:0] == 2'b00)
                       && (off < 32'(WIN_BYTES));

    logic              sel_cyc;
    logic              sel_ack;
    logic              sel_stat;
    logic              sel_mask;
    logic [NUM_CH-1:0] sel_cmp;

    assign sel_cyc  = TimerAddress && (off == 32'h0);
    assign sel_ack  = TimerAddress && (off == 32'h4);
    assign sel_stat = TimerAddress && (off == 32'h8);
    assign sel_mask = TimerAddress && (off == 32'hC);

    always_comb begin
        sel_cmp = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_cmp[i] = TimerAddress
                      && (off == 32'(CMP_OFF + 4 * i));
        end
    end

`ifdef MULTI_TIMER_PERIODIC_EN
    logic [NUM_CH-1:0] sel_per;

    always_comb begin
        sel_per = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_per[i] = TimerAddress
                      && (off == 32'(PER_OFF + 4 * i));
        end
    end
`endif

    logic we;
    assign we = MemWrite && TimerAddress;

    // ------------------------------------------------------------
    // State
    // ------------------------------------------------------------
    logic [WIDTH-1:0]  cycle_q, cycle_d;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0]  cmp_q [NUM_CH];
    logic [WIDTH-1:0]  cmp_d [NUM_CH];
`ifdef MULTI_TIMER_PERIODIC_EN
    logic [WIDTH-1:0]  per_q [NUM_CH];
    logic [WIDTH-1:0]  per_d [NUM_CH];
`endif

    logic [NUM_CH-1:0] match;
    logic [NUM_CH-1:0] ack;

    // ------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------
    always_comb begin
        cycle_d = cycle_q + WIDTH'(1);

        // Matches always use the registered compare value, so a
        // COMPARE write in a match cycle only affects later cycles.
        match = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            match[i] = (cycle_q == cmp_q[i]);
        end

        ack = (we && sel_ack) ? wdata[NUM_CH-1:0] : '0;

        // Set dominates clear on the same bit.
        pending_d = (pending_q & ~ack) | match;

        mask_d = (we && sel_mask) ? wdata[NUM_CH-1:0] : mask_q;

        for (int i = 0; i < NUM_CH; i++) begin
            cmp_d[i] = cmp_q[i];
`ifdef MULTI_TIMER_PERIODIC_EN
            per_d[i] = (we && sel_per[i]) ? wdata[WIDTH-1:0]
                                          : per_q[i];
            if (match[i] && (per_q[i] != '0)) begin
                cmp_d[i] = cmp_q[i] + per_q[i];
            end
`endif
            if (we && sel_cmp[i]) begin
                cmp_d[i] = wdata[WIDTH-1:0];
            end
        end
    end

    // ------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q   <= '0;
            pending_q <= '0;
            mask_q    <= '1;
            for (int i = 0; i < NUM_CH; i++) begin
                cmp_q[i] <= '1;
`ifdef MULTI_TIMER_PERIODIC_EN
                per_q[i] <= '0;
`endif
            end
        end else begin
            cycle_q   <= cycle_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cmp_q[i] <= cmp_d[i];
`ifdef MULTI_TIMER_PERIODIC_EN
                per_q[i] <= per_d[i];
`endif
            end
        end
    end

    // ------------------------------------------------------------
    // Read mux (ACK and holes read as zero)
    // ------------------------------------------------------------
    always_comb begin
        rdata = '0;
        if (MemRead && TimerAddress) begin
            unique case (1'b1)
                sel_cyc:  rdata = 32'(cycle_q);
                sel_stat: rdata = 32'(pending_q);
                sel_mask: rdata = 32'(mask_q);
                default:  rdata = '0;
            endcase
            for (int i = 0; i < NUM_CH; i++) begin
                if (sel_cmp[i]) begin
                    rdata = 32'(cmp_q[i]);
                end
`ifdef MULTI_TIMER_PERIODIC_EN
                if (sel_per[i]) begin
                    rdata = 32'(per_q[i]);
                end
`endif
            end
        end
    end

    // ------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------
    assign cycle          = cycle_q;
    assign pending        = pending_q;
    assign TimerInterrupt = |(pending_q & mask_q);

    // Upper store-data bits beyond WIDTH carry no state.
    logic unused_wdata;
    assign unused_wdata = ^wdata;

endmodule
